// File: rtl/decoder_scan.sv
// Registered one-hot decoder with a scan mode that walks a single hot bit
// across every output, holding each one for a programmable dwell.
module decoder_scan #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    start,
  output logic                    ready,
  input  logic [DWELL_W-1:0]      dwell,
  input  logic                    cont,
  output logic [(2**SEL_W)-1:0]   out,
  output logic                    busy,
  output logic                    wrap,
  output logic [SEL_W-1:0]        idx
);

  localparam int OUT_W = 2**SEL_W;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t              state;
  state_t              state_n;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic [DWELL_W-1:0]  dwell_cnt_n;
  logic [DWELL_W-1:0]  dwell_r;
  logic [DWELL_W-1:0]  dwell_r_n;
  logic [SEL_W-1:0]    start_idx;
  logic [SEL_W-1:0]    start_idx_n;
  logic [SEL_W-1:0]    idx_n;
  logic [SEL_W-1:0]    nxt;
  logic                cont_r;
  logic                cont_r_n;
  logic                busy_n;
  logic                wrap_n;
  logic [OUT_W-1:0]    out_n;
  logic                accept;
  logic                step_done;
  logic                last;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign ready     = ~busy;
  assign accept    = start & ready & en & mode;
  // Index increment relies on natural SEL_W-bit rollover to return to 0.
  assign nxt       = idx + SEL_W'(1);
  assign step_done = (dwell_cnt == '0);
  assign last      = (nxt == start_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out       <= '0;
      busy      <= 1'b0;
      wrap      <= 1'b0;
      idx       <= '0;
      dwell_cnt <= '0;
      dwell_r   <= '0;
      start_idx <= '0;
      cont_r    <= 1'b0;
    end else begin
      state     <= state_n;
      out       <= out_n;
      busy      <= busy_n;
      wrap      <= wrap_n;
      idx       <= idx_n;
      dwell_cnt <= dwell_cnt_n;
      dwell_r   <= dwell_r_n;
      start_idx <= start_idx_n;
      cont_r    <= cont_r_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SCAN;
        end
      end
      SCAN: begin
        // Dropping mode aborts regardless of en.
        if (!mode) begin
          state_n = IDLE;
        end else if (en && step_done && last && !cont_r) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    out_n       = out;
    busy_n      = busy;
    wrap_n      = 1'b0;
    idx_n       = idx;
    dwell_cnt_n = dwell_cnt;
    dwell_r_n   = dwell_r;
    start_idx_n = start_idx;
    cont_r_n    = cont_r;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        idx_n  = '0;
        if (!mode) begin
          out_n = en ? onehot(sel) : '0;
        end else if (accept) begin
          start_idx_n = sel;
          dwell_r_n   = dwell;
          cont_r_n    = cont;
          idx_n       = sel;
          out_n       = onehot(sel);
          dwell_cnt_n = dwell;
          busy_n      = 1'b1;
        end else begin
          out_n = '0;
        end
      end
      SCAN: begin
        if (!mode) begin
          busy_n = 1'b0;
          idx_n  = '0;
          out_n  = en ? onehot(sel) : '0;
        end else if (en) begin
          if (!step_done) begin
            dwell_cnt_n = dwell_cnt - DWELL_W'(1);
          end else if (!last || cont_r) begin
            idx_n       = nxt;
            out_n       = onehot(nxt);
            dwell_cnt_n = dwell_r;
            wrap_n      = last;
          end else begin
            wrap_n = 1'b1;
            out_n  = '0;
            idx_n  = '0;
            busy_n = 1'b0;
          end
        end
      end
      default: begin
        out_n  = '0;
        busy_n = 1'b0;
        idx_n  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: expected cycles are queued as stimulus is
// applied and popped against both the default and the wide instance.
module tb_decoder_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en, mode, start, cont;
  logic [2:0]  sel;
  logic [3:0]  dwell;
  logic        ready, busy, wrap;
  logic [7:0]  out;
  logic [2:0]  idx;

  logic        en6, mode6, start6, cont6;
  logic [3:0]  sel6;
  logic [1:0]  dwell6;
  logic        ready6, busy6, wrap6;
  logic [15:0] out6;
  logic [3:0]  idx6;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] out;
    logic        busy;
    logic        wrap;
    logic [3:0]  idx;
  } exp_t;

  exp_t sb[$];

  decoder_scan #(.SEL_W(3), .DWELL_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .start(start),
    .ready(ready), .dwell(dwell), .cont(cont), .out(out), .busy(busy),
    .wrap(wrap), .idx(idx)
  );

  decoder_scan #(.SEL_W(4), .DWELL_W(2)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .en(en6), .mode(mode6), .sel(sel6), .start(start6),
    .ready(ready6), .dwell(dwell6), .cont(cont6), .out(out6), .busy(busy6),
    .wrap(wrap6), .idx(idx6)
  );

  function automatic void pushExp(logic [15:0] o, logic b, logic w, logic [3:0] i);
    exp_t e;
    e.out  = o;
    e.busy = b;
    e.wrap = w;
    e.idx  = i;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic m, input logic e, input logic [2:0] s,
                               input logic st, input logic [3:0] d, input logic c);
    mode  = m;
    en    = e;
    sel   = s;
    start = st;
    dwell = d;
    cont  = c;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] o, input logic b,
                             input logic w, input logic [3:0] i, input logic r);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("[TB] FAIL %s scoreboard empty, observed out=%h", tag, o);
      return;
    end
    e = sb.pop_front();
    assert (o === e.out) else begin
      failures++;
      $error("[TB] FAIL %s out observed=%h expected=%h", tag, o, e.out);
    end
    checks++;
    assert (b === e.busy) else begin
      failures++;
      $error("[TB] FAIL %s busy observed=%b expected=%b", tag, b, e.busy);
    end
    checks++;
    assert (w === e.wrap) else begin
      failures++;
      $error("[TB] FAIL %s wrap observed=%b expected=%b", tag, w, e.wrap);
    end
    checks++;
    assert (i === e.idx) else begin
      failures++;
      $error("[TB] FAIL %s idx observed=%h expected=%h", tag, i, e.idx);
    end
    checks++;
    assert (r === ~e.busy) else begin
      failures++;
      $error("[TB] FAIL %s ready observed=%b expected=%b", tag, r, ~e.busy);
    end
  endtask

  task automatic check8(input string tag);
    checkOutput(tag, {8'h00, out}, busy, wrap, {1'b0, idx}, ready);
  endtask

  task automatic check16(input string tag);
    checkOutput(tag, out6, busy6, wrap6, idx6, ready6);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [2:0] ix3;
    logic [3:0] ix4;

    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0);
    en6 = 1'b0; mode6 = 1'b0; start6 = 1'b0; cont6 = 1'b0; sel6 = '0; dwell6 = '0;
    #12;
    pushExp(16'h0000, 1'b0, 1'b0, 4'd0);
    check8("reset");
    pushExp(16'h0000, 1'b0, 1'b0, 4'd0);
    check16("reset_wide");
    #1 rst_n = 1'b1;

    // T1 direct decode
    applyStimulus(1'b0, 1'b1, 3'd5, 1'b0, 4'd0, 1'b0);
    pushExp(16'h0020, 1'b0, 1'b0, 4'd0);
    tick();
    check8("t1_sel5");
    sel = 3'd0;
    pushExp(16'h0001, 1'b0, 1'b0, 4'd0);
    tick();
    check8("t1_sel0");
    en = 1'b0;
    pushExp(16'h0000, 1'b0, 1'b0, 4'd0);
    tick();
    check8("t1_en0");
    applyStimulus(1'b1, 1'b1, 3'd3, 1'b0, 4'd0, 1'b0);
    pushExp(16'h0000, 1'b0, 1'b0, 4'd0);
    tick();
    check8("t1_scan_idle");

    // T2 single scan
    applyStimulus(1'b1, 1'b1, 3'd6, 1'b1, 4'd1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      ix3 = 3'(6 + k);
      for (int r = 0; r < 2; r++) pushExp(16'd1 << ix3, 1'b1, 1'b0, {1'b0, ix3});
    end
    pushExp(16'h0000, 1'b0, 1'b1, 4'd0);
    pushExp(16'h0000, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i == 0) start = 1'b0;
      check8("t2_scan");
    end

    // T3 pause while out=02
    applyStimulus(1'b1, 1'b1, 3'd6, 1'b1, 4'd1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      ix3 = 3'(6 + k);
      for (int r = 0; r < 2; r++) begin
        pushExp(16'd1 << ix3, 1'b1, 1'b0, {1'b0, ix3});
        if (k == 3 && r == 0) begin
          for (int p = 0; p < 3; p++) pushExp(16'h0002, 1'b1, 1'b0, 4'd1);
        end
      end
    end
    pushExp(16'h0000, 1'b0, 1'b1, 4'd0);
    pushExp(16'h0000, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 21; i++) begin
      tick();
      if (i == 0) start = 1'b0;
      if (i == 6) en = 1'b0;
      if (i == 9) en = 1'b1;
      check8("t3_pause");
    end

    // T4 continuous scan with an ignored start, then abort
    applyStimulus(1'b1, 1'b1, 3'd0, 1'b1, 4'd0, 1'b1);
    for (int k = 0; k < 24; k++) begin
      ix3 = 3'(k);
      pushExp(16'd1 << ix3, 1'b1, (k != 0 && ix3 == 3'd0), {1'b0, ix3});
    end
    for (int i = 0; i < 24; i++) begin
      tick();
      if (i == 0) start = 1'b0;
      if (i == 3) begin
        start = 1'b1;
        sel   = 3'd5;
        dwell = 4'd7;
        cont  = 1'b0;
      end
      if (i == 4) start = 1'b0;
      check8("t4_cont");
    end
    mode = 1'b0;
    sel  = 3'd3;
    pushExp(16'h0008, 1'b0, 1'b0, 4'd0);
    tick();
    check8("t4_abort");

    // T5 asynchronous reset mid-dwell
    applyStimulus(1'b1, 1'b1, 3'd2, 1'b1, 4'd5, 1'b0);
    for (int i = 0; i < 3; i++) pushExp(16'h0004, 1'b1, 1'b0, 4'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) start = 1'b0;
      check8("t5_pre_reset");
    end
    #2 rst_n = 1'b0;
    #1;
    pushExp(16'h0000, 1'b0, 1'b0, 4'd0);
    check8("t5_async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    pushExp(16'h0000, 1'b0, 1'b0, 4'd0);
    tick();
    check8("t5_after_reset");

    // T6 wide instance, index rollover from 15 to 0
    mode6 = 1'b1; en6 = 1'b1; sel6 = 4'd15; dwell6 = 2'd3; cont6 = 1'b0; start6 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ix4 = 4'(15 + k);
      for (int r = 0; r < 4; r++) pushExp(16'd1 << ix4, 1'b1, 1'b0, ix4);
    end
    pushExp(16'h0000, 1'b0, 1'b1, 4'd0);
    pushExp(16'h0000, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 66; i++) begin
      tick();
      if (i == 0) start6 = 1'b0;
      check16("t6_wide");
    end

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
